// File: rtl/gate_response_checker.sv
// Response-side checker for gate-level lab DUTs: drives each accepted vector, waits SETTLE cycles, then
// compares dut_out to the golden OP function. Define GATE_CHK_COVERAGE_EN to add cov_mask/cov_full outputs.
module gate_response_checker #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 2,
   parameter int OP     = 0,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vec_valid,
   input  logic [N_IN-1:0]  vec_in,
   input  logic             vec_last,
   output logic             vec_ready,
   output logic [N_IN-1:0]  dut_in,
   input  logic             dut_out,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err,
   output logic [N_IN-1:0]  fail_vec,
   output logic             fail_got,
   output logic             done
`ifdef GATE_CHK_COVERAGE_EN
   ,
   output logic [2**N_IN-1:0] cov_mask,
   output logic               cov_full
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

   localparam logic [3:0] SETTLE_L = 4'(SETTLE);

   state_t     state_q, state_d;
   logic [3:0] settle_q;
   logic       last_q;
   logic       accept;
   logic       check_en;
   logic       match;

   function automatic logic golden(input logic [N_IN-1:0] v);
      case (OP)
         1:       return |v;
         2:       return ~&v;
         3:       return ~|v;
         4:       return ^v;
         default: return &v;
      endcase
   endfunction

   assign match = (dut_out == golden(dut_in));

   // NOTE: sequential state is updated with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      check_en  = 1'b0;
      vec_ready = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            vec_ready = 1'b1;
            if (vec_valid) begin
               accept  = 1'b1;
               state_d = (SETTLE_L != 4'd0) ? WAIT : CHECK;
            end
         end
         WAIT: begin
            if (settle_q <= 4'd1) state_d = CHECK;
         end
         CHECK: begin
            check_en = 1'b1;
            state_d  = last_q ? DONE : IDLE;
         end
         DONE: begin
            done = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dut_in   <= '0;
         last_q   <= 1'b0;
         settle_q <= '0;
         pass_cnt <= '0;
         fail_cnt <= '0;
         err      <= 1'b0;
         fail_vec <= '0;
         fail_got <= 1'b0;
      end else begin
         if (accept) begin
            dut_in   <= vec_in;
            last_q   <= vec_last;
            settle_q <= SETTLE_L;
         end else if (state_q == WAIT) begin
            settle_q <= settle_q - 4'd1;
         end

         // Counters saturate; err and first-failure capture still happen when fail_cnt is pinned.
         if (check_en) begin
            if (match) begin
               if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
               if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
               err <= 1'b1;
               if (!err) begin
                  fail_vec <= dut_in;
                  fail_got <= dut_out;
               end
            end
         end
      end
   end

`ifdef GATE_CHK_COVERAGE_EN
   logic [2**N_IN-1:0] cov_next;

   always_comb begin
      cov_next         = cov_mask;
      cov_next[dut_in] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cov_mask <= '0;
         cov_full <= 1'b0;
      end else if (check_en) begin
         cov_mask <= cov_next;
         cov_full <= &cov_next;
      end
   end
`endif

endmodule
